// File: rtl/m8c_issp_target.sv
`default_nettype none
// ============================================================================
// Module   : m8c_issp_target
// Purpose  : Responder end of the M8C ISSP serial link (POR handshake,
//            22-bit vector shifting, read return, execute busy/ready).
// Revision : 1.0  initial release
// ============================================================================
module m8c_issp_target #(
    parameter int          VEC_SIZE       = 22,
    parameter int          POR_HI_CYCLES  = 15000,
    parameter int          POR_LO_CYCLES  = 4,
    parameter int          EXEC_BUSY_CLKS = 8,
    parameter int          EXEC_ZERO_BITS = 40,
    parameter logic [7:0]  EXEC_REG       = 8'hFF
) (
    input  logic                osc,
    input  logic                rst_n,
    input  logic                vdd_on,
    input  logic                sclk,
    input  logic                sdata_in,
    output logic                sdata_out,
    output logic                sdata_oe,
    output logic                vec_valid,
    output logic [VEC_SIZE-1:0] vec_data,
    output logic                exec_pulse,
    input  logic [7:0]          dbg_addr,
    output logic [7:0]          dbg_data
);

    localparam logic [2:0] c_ST_OFF   = 3'd0;
    localparam logic [2:0] c_ST_PORHI = 3'd1;
    localparam logic [2:0] c_ST_PORLO = 3'd2;
    localparam logic [2:0] c_ST_SHIFT = 3'd3;
    localparam logic [2:0] c_ST_BUSY  = 3'd4;
    localparam logic [2:0] c_ST_READY = 3'd5;
    localparam logic [2:0] c_ST_ZERO  = 3'd6;

    localparam int c_POR_W  = $clog2(POR_HI_CYCLES + 1);
    localparam int c_EXEC_W = $clog2(EXEC_ZERO_BITS + EXEC_BUSY_CLKS + 1);
    localparam int c_BIT_W  = $clog2(VEC_SIZE);

    localparam logic [c_POR_W-1:0]  c_POR_HI_LAST = c_POR_W'(POR_HI_CYCLES - 1);
    localparam logic [c_POR_W-1:0]  c_POR_LO_LAST = c_POR_W'(POR_LO_CYCLES - 1);
    localparam logic [c_EXEC_W-1:0] c_BUSY_LAST   = c_EXEC_W'(EXEC_BUSY_CLKS - 1);
    localparam logic [c_EXEC_W-1:0] c_ZERO_LAST   = c_EXEC_W'(EXEC_ZERO_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST    = c_BIT_W'(VEC_SIZE - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LATCH   = c_BIT_W'(10);
    localparam logic [c_BIT_W-1:0]  c_RD_HI       = c_BIT_W'(9);
    localparam logic [c_BIT_W-1:0]  c_RD_LO       = c_BIT_W'(2);

    logic [2:0]          r_state;
    logic                r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic                r_sd_s1, r_sd_s2;
    logic [c_POR_W-1:0]  r_por_cnt;
    logic [c_EXEC_W-1:0] r_exec_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [VEC_SIZE-2:0] r_shift;
    logic [7:0]          r_rd_data;
    logic                r_is_read;
    logic [7:0]          r_mem [256];
    logic [7:0]          r_reg [256];

    logic                w_rise, w_fall, w_bit, w_in_rd, w_rd_bit;
    logic                w_commit, w_mem_we, w_reg_we, w_exec_arm;
    logic [VEC_SIZE-1:0] w_vec;

    always_ff @(posedge osc) begin
        if (!rst_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_sd_s1   <= 1'b0;
            r_sd_s2   <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_sd_s1   <= sdata_in;
            r_sd_s2   <= r_sd_s1;
        end
    end

    assign w_rise   = r_sclk_s2 & ~r_sclk_d;
    assign w_fall   = ~r_sclk_s2 & r_sclk_d;
    // While we drive the pin, the bit we capture is our own drive value.
    assign w_bit    = sdata_oe ? sdata_out : r_sd_s2;
    assign w_vec    = {r_shift, w_bit};
    assign w_in_rd  = r_is_read && (r_bit_cnt <= c_RD_HI) && (r_bit_cnt >= c_RD_LO);
    assign w_rd_bit = r_rd_data[3'(r_bit_cnt - c_RD_LO)];

    assign w_commit   = rst_n && vdd_on && (r_state == c_ST_SHIFT) && w_fall
                        && (r_bit_cnt == '0);
    assign w_mem_we   = w_commit && (w_vec[21:19] == 3'b100) && (w_vec[2:0] == 3'b111);
    assign w_reg_we   = w_commit && (w_vec[21:19] == 3'b110) && (w_vec[2:0] == 3'b111);
    assign w_exec_arm = w_reg_we && (w_vec[18:11] == EXEC_REG);

    assign dbg_data = r_mem[dbg_addr];

    always_ff @(posedge osc) begin
        if (w_mem_we) r_mem[w_vec[18:11]] <= w_vec[10:3];
        if (w_reg_we) r_reg[w_vec[18:11]] <= w_vec[10:3];
    end

    always_ff @(posedge osc) begin
        if (!rst_n) begin
            r_state    <= c_ST_OFF;
            sdata_oe   <= 1'b0;
            sdata_out  <= 1'b0;
            vec_valid  <= 1'b0;
            exec_pulse <= 1'b0;
            vec_data   <= '0;
            r_por_cnt  <= '0;
            r_exec_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rd_data  <= '0;
            r_is_read  <= 1'b0;
        end else if (!vdd_on) begin
            r_state    <= c_ST_OFF;
            sdata_oe   <= 1'b0;
            sdata_out  <= 1'b0;
            vec_valid  <= 1'b0;
            exec_pulse <= 1'b0;
            r_por_cnt  <= '0;
            r_exec_cnt <= '0;
            r_bit_cnt  <= '0;
            r_is_read  <= 1'b0;
        end else begin
            vec_valid  <= 1'b0;
            exec_pulse <= 1'b0;
            case (r_state)
                c_ST_OFF: begin
                    r_state   <= c_ST_PORHI;
                    sdata_oe  <= 1'b1;
                    sdata_out <= 1'b1;
                    r_por_cnt <= '0;
                end
                c_ST_PORHI: begin
                    if (r_por_cnt == c_POR_HI_LAST) begin
                        r_state   <= c_ST_PORLO;
                        sdata_out <= 1'b0;
                        r_por_cnt <= '0;
                    end else begin
                        r_por_cnt <= r_por_cnt + c_POR_W'(1);
                    end
                end
                c_ST_PORLO: begin
                    if (w_rise || (r_por_cnt == c_POR_LO_LAST)) begin
                        r_state   <= c_ST_SHIFT;
                        sdata_oe  <= 1'b0;
                        r_bit_cnt <= c_BIT_LAST;
                    end else begin
                        r_por_cnt <= r_por_cnt + c_POR_W'(1);
                    end
                end
                c_ST_SHIFT: begin
                    if (w_rise) begin
                        sdata_oe  <= w_in_rd;
                        sdata_out <= w_in_rd ? w_rd_bit : 1'b0;
                    end
                    if (w_fall) begin
                        r_shift <= w_vec[VEC_SIZE-2:0];
                        // Prefix and address sit in the low 11 shifted bits here.
                        if (r_bit_cnt == c_BIT_LATCH) begin
                            r_is_read <= r_shift[10] & r_shift[8];
                            r_rd_data <= r_shift[9] ? r_reg[r_shift[7:0]] : r_mem[r_shift[7:0]];
                        end
                        if (r_bit_cnt == '0) begin
                            r_bit_cnt <= c_BIT_LAST;
                            vec_data  <= w_vec;
                            vec_valid <= 1'b1;
                            if (w_exec_arm) begin
                                r_state    <= c_ST_BUSY;
                                sdata_oe   <= 1'b1;
                                sdata_out  <= 1'b1;
                                r_exec_cnt <= '0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt - c_BIT_W'(1);
                        end
                    end
                end
                c_ST_BUSY: begin
                    if (w_fall) begin
                        if (r_exec_cnt == c_BUSY_LAST) begin
                            r_state    <= c_ST_READY;
                            sdata_out  <= 1'b0;
                            r_exec_cnt <= '0;
                        end else begin
                            r_exec_cnt <= r_exec_cnt + c_EXEC_W'(1);
                        end
                    end
                end
                c_ST_READY: begin
                    if (w_fall) begin
                        r_state  <= c_ST_ZERO;
                        sdata_oe <= 1'b0;
                    end
                end
                c_ST_ZERO: begin
                    if (w_fall) begin
                        if (r_exec_cnt == c_ZERO_LAST) begin
                            r_state    <= c_ST_SHIFT;
                            exec_pulse <= 1'b1;
                            r_exec_cnt <= '0;
                            r_bit_cnt  <= c_BIT_LAST;
                        end else begin
                            r_exec_cnt <= r_exec_cnt + c_EXEC_W'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= c_ST_OFF;
                    sdata_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m8c_issp_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_m8c_issp_target
// Purpose  : Self-checking bench for m8c_issp_target with a vector scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_m8c_issp_target;

    logic        osc = 1'b0;
    logic        rst_n, vdd_on, sclk, host_d;
    logic        sdata_out, sdata_oe, vec_valid, exec_pulse;
    logic [21:0] vec_data;
    logic [7:0]  dbg_addr, dbg_data;
    logic        w_bus;

    int n_checks = 0;
    int n_pass   = 0;
    int n_exec   = 0;
    int n_valid  = 0;
    logic [21:0] exp_q [$];

    assign w_bus = sdata_oe ? sdata_out : host_d;

    always #5 osc = ~osc;

    m8c_issp_target dut (
        .osc(osc), .rst_n(rst_n), .vdd_on(vdd_on), .sclk(sclk),
        .sdata_in(w_bus), .sdata_out(sdata_out), .sdata_oe(sdata_oe),
        .vec_valid(vec_valid), .vec_data(vec_data), .exec_pulse(exec_pulse),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Scoreboard: every reported vector must match the oldest expected one.
    always @(negedge osc) begin
        if (exec_pulse) n_exec++;
        if (vec_valid) begin
            n_valid++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL vec_unexpected: got vec_data=%h, required no vector", vec_data);
            end else begin
                logic [21:0] exp_v;
                exp_v = exp_q.pop_front();
                if (vec_data !== exp_v)
                    $display("FAIL vec_data: got %h, required %h", vec_data, exp_v);
                else
                    n_pass++;
            end
        end
    end

    task automatic sclk_bit(input logic d, output logic b, output logic o);
        @(negedge osc);
        host_d = d;
        sclk   = 1'b1;
        repeat (5) @(negedge osc);
        b    = w_bus;
        o    = sdata_oe;
        sclk = 1'b0;
        repeat (5) @(negedge osc);
    endtask

    task automatic send_vec(input logic [21:0] v, input int nbits,
                            output logic [21:0] rd, output logic [21:0] oe_seen);
        logic b, o;
        rd = '0;
        oe_seen = '0;
        for (int i = 21; i > 21 - nbits; i--) begin
            sclk_bit(v[i], b, o);
            rd[i] = b;
            oe_seen[i] = o;
        end
    endtask

    task automatic do_por(input string tag);
        int t, hi, lo;
        @(negedge osc);
        vdd_on = 1'b1;
        t = 0;
        while (!sdata_oe && t < 10) begin @(negedge osc); t++; end
        n_checks++;
        if (t !== 1) $display("FAIL %s_start: oe rose after %0d cycles, required 1", tag, t);
        else n_pass++;
        hi = 0;
        while (sdata_oe && sdata_out && hi < 20000) begin hi++; @(negedge osc); end
        n_checks++;
        if (hi !== 15000) $display("FAIL %s_hi: high for %0d cycles, required 15000", tag, hi);
        else n_pass++;
        lo = 0;
        while (sdata_oe && !sdata_out && lo < 100) begin lo++; @(negedge osc); end
        n_checks++;
        if (lo !== 4 || sdata_oe !== 1'b0)
            $display("FAIL %s_lo: low for %0d cycles oe=%b, required 4 and oe=0", tag, lo, sdata_oe);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vdd_on = 1'b0; sclk = 1'b0; host_d = 1'b0; dbg_addr = 8'h00;
        repeat (4) @(negedge osc);
        n_checks++;
        if ({sdata_oe, sdata_out, vec_valid, exec_pulse} !== 4'b0000)
            $display("FAIL reset_outs: got oe/out/valid/pulse=%b, required 0000",
                     {sdata_oe, sdata_out, vec_valid, exec_pulse});
        else n_pass++;
        n_checks++;
        if (vec_data !== 22'h0) $display("FAIL reset_vec: got %h, required 0", vec_data);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge osc);
    endtask

    task automatic test_mem_write();
        logic [21:0] rd, oe_s;
        exp_q.push_back({3'b100, 8'h3C, 8'hA5, 3'b111});
        send_vec({3'b100, 8'h3C, 8'hA5, 3'b111}, 22, rd, oe_s);
        exp_q.push_back({3'b100, 8'h3D, 8'h22, 3'b111});
        send_vec({3'b100, 8'h3D, 8'h22, 3'b111}, 22, rd, oe_s);
        // Bad trailer: reported but must not write.
        exp_q.push_back({3'b100, 8'h3D, 8'h11, 3'b110});
        send_vec({3'b100, 8'h3D, 8'h11, 3'b110}, 22, rd, oe_s);
        dbg_addr = 8'h3C;
        @(negedge osc);
        n_checks++;
        if (dbg_data !== 8'hA5) $display("FAIL mem_write: dbg_data=%h, required a5", dbg_data);
        else n_pass++;
        dbg_addr = 8'h3D;
        @(negedge osc);
        n_checks++;
        if (dbg_data !== 8'h22) $display("FAIL bad_trailer: dbg_data=%h, required 22", dbg_data);
        else n_pass++;
    endtask

    task automatic test_mem_read();
        logic [21:0] rd, oe_s;
        exp_q.push_back({3'b101, 8'h3C, 1'b0, 8'hA5, 1'b0, 1'b1});
        send_vec({3'b101, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1}, 22, rd, oe_s);
        n_checks++;
        if (oe_s !== 22'h0003FC) $display("FAIL read_oe: oe pattern %h, required 0003fc", oe_s);
        else n_pass++;
        n_checks++;
        if (rd[9:2] !== 8'hA5) $display("FAIL read_data: host saw %h, required a5", rd[9:2]);
        else n_pass++;
    endtask

    task automatic test_reg_space();
        logic [21:0] rd, oe_s;
        exp_q.push_back({3'b110, 8'h3C, 8'h5A, 3'b111});
        send_vec({3'b110, 8'h3C, 8'h5A, 3'b111}, 22, rd, oe_s);
        exp_q.push_back({3'b111, 8'h3C, 1'b0, 8'h5A, 1'b0, 1'b1});
        send_vec({3'b111, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1}, 22, rd, oe_s);
        n_checks++;
        if (rd[9:2] !== 8'h5A) $display("FAIL reg_read: host saw %h, required 5a", rd[9:2]);
        else n_pass++;
        dbg_addr = 8'h3C;
        @(negedge osc);
        n_checks++;
        if (dbg_data !== 8'hA5) $display("FAIL reg_isolation: mem=%h, required a5", dbg_data);
        else n_pass++;
    endtask

    task automatic test_exec();
        logic [21:0] rd, oe_s;
        logic [7:0] busy_b;
        logic b, o, zero_oe;
        int ex0;
        exp_q.push_back({3'b110, 8'hFF, 8'h00, 3'b111});
        send_vec({3'b110, 8'hFF, 8'h00, 3'b111}, 22, rd, oe_s);
        ex0 = n_exec;
        busy_b = '0;
        for (int k = 0; k < 8; k++) begin
            sclk_bit(1'b0, b, o);
            busy_b[k] = b & o;
        end
        n_checks++;
        if (busy_b !== 8'hFF) $display("FAIL exec_busy: busy bits %b, required 11111111", busy_b);
        else n_pass++;
        sclk_bit(1'b1, b, o);
        n_checks++;
        if ({o, b} !== 2'b10) $display("FAIL exec_ready: oe/bit=%b, required 10", {o, b});
        else n_pass++;
        zero_oe = 1'b0;
        for (int k = 0; k < 39; k++) begin
            sclk_bit(1'b0, b, o);
            zero_oe |= o;
        end
        n_checks++;
        if (zero_oe !== 1'b0 || n_exec !== ex0)
            $display("FAIL exec_zero: oe_seen=%b pulses=%0d, required 0 and %0d", zero_oe, n_exec, ex0);
        else n_pass++;
        sclk_bit(1'b0, b, o);
        repeat (3) @(negedge osc);
        n_checks++;
        if (n_exec !== ex0 + 1) $display("FAIL exec_pulse: pulses=%0d, required %0d", n_exec, ex0 + 1);
        else n_pass++;
    endtask

    task automatic test_vdd_drop();
        logic [21:0] rd, oe_s;
        int nv0;
        exp_q.push_back({3'b100, 8'h55, 8'h77, 3'b111});
        send_vec({3'b100, 8'h55, 8'h77, 3'b111}, 22, rd, oe_s);
        nv0 = n_valid;
        send_vec({3'b100, 8'h55, 8'h12, 3'b111}, 10, rd, oe_s);
        @(negedge osc);
        vdd_on = 1'b0;
        send_vec({3'b100, 8'h55, 8'h12, 3'b111} << 10, 12, rd, oe_s);
        dbg_addr = 8'h55;
        @(negedge osc);
        n_checks++;
        if (dbg_data !== 8'h77 || n_valid !== nv0)
            $display("FAIL vdd_drop: mem=%h valids=%0d, required 77 and %0d", dbg_data, n_valid, nv0);
        else n_pass++;
        // Drop again while the POR drive is active: release must be immediate.
        vdd_on = 1'b1;
        repeat (100) @(negedge osc);
        vdd_on = 1'b0;
        @(negedge osc);
        n_checks++;
        if (sdata_oe !== 1'b0) $display("FAIL vdd_release: oe=%b, required 0", sdata_oe);
        else n_pass++;
        repeat (5) @(negedge osc);
        do_por("repor");
        exp_q.push_back({3'b101, 8'h55, 1'b0, 8'h77, 1'b0, 1'b1});
        send_vec({3'b101, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1}, 22, rd, oe_s);
        n_checks++;
        if (rd[9:2] !== 8'h77) $display("FAIL repor_read: host saw %h, required 77", rd[9:2]);
        else n_pass++;
    endtask

    task automatic test_reset_in_busy();
        logic [21:0] rd, oe_s;
        logic b, o;
        int ex0;
        exp_q.push_back({3'b110, 8'hFF, 8'h01, 3'b111});
        send_vec({3'b110, 8'hFF, 8'h01, 3'b111}, 22, rd, oe_s);
        ex0 = n_exec;
        for (int k = 0; k < 3; k++) sclk_bit(1'b0, b, o);
        n_checks++;
        if (sdata_oe !== 1'b1) $display("FAIL busy_entry: oe=%b, required 1", sdata_oe);
        else n_pass++;
        rst_n = 1'b0;
        @(negedge osc);
        n_checks++;
        if ({sdata_oe, sdata_out, vec_valid, exec_pulse} !== 4'b0000 || vec_data !== 22'h0)
            $display("FAIL busy_reset: oe/out/valid/pulse=%b vec=%h, required 0000 and 0",
                     {sdata_oe, sdata_out, vec_valid, exec_pulse}, vec_data);
        else n_pass++;
        for (int k = 0; k < 55; k++) sclk_bit(1'b0, b, o);
        n_checks++;
        if (n_exec !== ex0) $display("FAIL busy_reset_pulse: pulses=%0d, required %0d", n_exec, ex0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        do_por("por");
        test_mem_write();
        test_mem_read();
        test_reg_space();
        test_exec();
        test_vdd_drop();
        test_reset_in_busy();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL sb_drain: %0d vectors never reported, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
